// File: rtl/bram_add_pkg.sv
// bram_add_pkg: shared state encoding, default widths and read-latency limits
package bram_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/bram_add_pipe.sv
// bram_add_pipe: read-latency delay line, adder and write-stage registers
module bram_add_pipe #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [ADDR_W-1:0] r_base_i,
  input  logic [DATA_W-1:0] a_dout_i,
  input  logic [DATA_W-1:0] b_dout_i,
  output logic              pending_o,
  output logic              r_we_o,
  output logic [ADDR_W-1:0] r_addr_o,
  output logic [DATA_W-1:0] r_din_o,
  output logic              carry_o
);
  logic [RD_LAT-1:0] v_q;
  logic [ADDR_W-1:0] idx_q [RD_LAT];
  logic              r_we_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W:0]   sum_q;
  logic [DATA_W:0]   sum_d;
  assign sum_d = {1'b0, a_dout_i} + {1'b0, b_dout_i};
  // the last delay-line slot lines up with the cycle the BRAM data returns
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
      r_we_q <= 1'b0;
      r_addr_q <= '0;
      sum_q <= '0;
    end else begin
      v_q[0] <= issue_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      r_we_q <= v_q[RD_LAT-1];
      if (v_q[RD_LAT-1]) begin
        r_addr_q <= r_base_i + idx_q[RD_LAT-1];
        sum_q <= sum_d;
      end
    end
  assign pending_o = |v_q;
  assign r_we_o = r_we_q;
  assign r_addr_o = r_addr_q;
  assign r_din_o = sum_q[DATA_W-1:0];
  assign carry_o = sum_q[DATA_W];
endmodule

// File: rtl/bram_add_seq.sv
// bram_add_seq: start/done sequencer issuing one A/B read pair per cycle
// and writing each sum to R, with a sticky carry-out flag per run.
module bram_add_seq
  import bram_add_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = RD_LAT_MIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] r_base,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              a_en,
  output logic              b_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_dout,
  input  logic [DATA_W-1:0] b_dout,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_din
);
  state_t            state_q;
  logic [ADDR_W-1:0] k_q, len_q, a_base_q, b_base_q, r_base_q;
  logic              ovf_q, pending, carry;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      len_q <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      r_base_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (r_we & carry);
      case (state_q)
        IDLE: if (start) begin
          ovf_q <= 1'b0;
          len_q <= len;
          a_base_q <= a_base;
          b_base_q <= b_base;
          r_base_q <= r_base;
          k_q <= '0;
          state_q <= (len == '0) ? DONE : RUN;
        end
        RUN: begin
          k_q <= k_q + 1'b1;
          if (k_q == len_q - 1'b1) state_q <= DRAIN;
        end
        DRAIN: if (!pending) state_q <= DONE;
        DONE: state_q <= IDLE;
      endcase
    end
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign ovf = ovf_q;
  assign a_en = state_q == RUN;
  assign b_en = state_q == RUN;
  assign a_addr = a_base_q + k_q;
  assign b_addr = b_base_q + k_q;
  bram_add_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .issue_i(a_en),
    .idx_i(k_q),
    .r_base_i(r_base_q),
    .a_dout_i(a_dout),
    .b_dout_i(b_dout),
    .pending_o(pending),
    .r_we_o(r_we),
    .r_addr_o(r_addr),
    .r_din_o(r_din),
    .carry_o(carry)
  );
endmodule

// File: tb/tb_bram_add_seq.sv
// tb_bram_add_seq: directed runs on RD_LAT=1 and RD_LAT=2 instances with a write scoreboard
module tb_bram_add_seq;
  typedef struct {
    bit          d;
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic [7:0] len = '0, a_base = '0, b_base = '0, r_base = '0;
  logic busy1, done1, ovf1, a_en1, b_en1, r_we1;
  logic busy2, done2, ovf2, a_en2, b_en2, r_we2;
  logic [7:0] a_addr1, b_addr1, r_addr1, a_addr2, b_addr2, r_addr2;
  logic [15:0] a_dout1 = '0, b_dout1 = '0, a_dout2 = '0, b_dout2 = '0, a_p2 = '0, b_p2 = '0;
  logic [15:0] r_din1, r_din2;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  wr_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_add_seq #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .len(len), .a_base(a_base), .b_base(b_base),
    .r_base(r_base), .busy(busy1), .done(done1), .ovf(ovf1), .a_en(a_en1), .b_en(b_en1),
    .a_addr(a_addr1), .b_addr(b_addr1), .a_dout(a_dout1), .b_dout(b_dout1), .r_we(r_we1),
    .r_addr(r_addr1), .r_din(r_din1));

  bram_add_seq #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .len(len), .a_base(a_base), .b_base(b_base),
    .r_base(r_base), .busy(busy2), .done(done2), .ovf(ovf2), .a_en(a_en2), .b_en(b_en2),
    .a_addr(a_addr2), .b_addr(b_addr2), .a_dout(a_dout2), .b_dout(b_dout2), .r_we(r_we2),
    .r_addr(r_addr2), .r_din(r_din2));

  always @(posedge clk) begin
    if (a_en1) a_dout1 <= mem_a[a_addr1];
    if (b_en1) b_dout1 <= mem_b[b_addr1];
    if (a_en2) a_p2 <= mem_a[a_addr2];
    if (b_en2) b_p2 <= mem_b[b_addr2];
    a_dout2 <= a_p2;
    b_dout2 <= b_p2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic we;
      logic [7:0] ad;
      logic [15:0] dn;
      bit here;
      we = d ? r_we2 : r_we1;
      ad = d ? r_addr2 : r_addr1;
      dn = d ? r_din2 : r_din1;
      here = sb.size() > 0 && sb[0].d == bit'(d) && sb[0].cyc == cyc;
      if (we || here) begin
        chk($sformatf("write%0d_cyc%0d", d, cyc), {7'd0, we, ad, dn},
            here ? {7'd0, 1'b1, sb[0].addr, sb[0].data} : 32'h0);
        if (here) void'(sb.pop_front());
      end
    end
  endtask

  task automatic rst_chk(input string tag, input bit d);
    chk({tag, "_flags"}, d ? {busy2, done2, ovf2, a_en2, b_en2, r_we2} : {busy1, done1, ovf1, a_en1, b_en1, r_we1}, 0);
    chk({tag, "_addrs"}, d ? {a_addr2, b_addr2, r_addr2} : {a_addr1, b_addr1, r_addr1}, 0);
    chk({tag, "_rdin"}, d ? r_din2 : r_din1, 0);
  endtask

  task automatic go(input bit d2, input logic [7:0] l, ab, bb, rb, input bit poke);
    int lat;
    logic cy;
    logic [16:0] s;
    logic bz, dn, ae, be, ov;
    logic [7:0] aa, ba;
    lat = d2 ? 2 : 1;
    cy = 1'b0;
    len = l; a_base = ab; b_base = bb; r_base = rb;
    for (int k = 0; k < int'(l); k++) begin
      s = {1'b0, mem_a[8'(int'(ab) + k)]} + {1'b0, mem_b[8'(int'(bb) + k)]};
      cy |= s[16];
      sb.push_back('{d2, 2 + k + lat, 8'(int'(rb) + k), s[15:0]});
    end
    cyc = 0;
    if (d2) start2 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    while (cyc < 300) begin
      bz = d2 ? busy2 : busy1; dn = d2 ? done2 : done1; ov = d2 ? ovf2 : ovf1;
      ae = d2 ? a_en2 : a_en1; be = d2 ? b_en2 : b_en1;
      aa = d2 ? a_addr2 : a_addr1; ba = d2 ? b_addr2 : b_addr1;
      if (poke && cyc == 2) begin if (d2) start2 = 1'b1; else start1 = 1'b1; end
      if (poke && cyc == 3) begin start1 = 1'b0; start2 = 1'b0; end
      if (cyc == 1) chk("ovf_cleared", ov, 0);
      chk($sformatf("busy_cyc%0d", cyc), bz, l != 0 && cyc <= 1 + int'(l) + lat);
      chk($sformatf("en_cyc%0d", cyc), {ae, be}, (cyc <= int'(l)) ? 2'b11 : 2'b00);
      if (cyc <= int'(l)) chk($sformatf("raddr_cyc%0d", cyc), {aa, ba}, {8'(int'(ab) + cyc - 1), 8'(int'(bb) + cyc - 1)});
      if (dn) break;
      tick();
    end
    chk("done_cycle", cyc, l == 0 ? 1 : 2 + int'(l) + lat);
    chk("busy_at_done", d2 ? busy2 : busy1, 0);
    chk("ovf_at_done", d2 ? ovf2 : ovf1, cy);
    tick();
    chk("done_pulse", d2 ? done2 : done1, 0);
    chk("ovf_held", d2 ? ovf2 : ovf1, cy);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    repeat (2) @(posedge clk);
    tick();
    rst_chk("por1", 0);
    rst_chk("por2", 1);
    rst_n = 1'b1;
    tick();
    // mid-run reset: only the first write lands before rst_n drops in cycle 3
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 16'(i);
      mem_b[16 + i] = 16'h0100;
    end
    len = 8'd4; a_base = 8'h00; b_base = 8'h10; r_base = 8'h20;
    sb.push_back('{1'b0, 3, 8'h20, 16'h0100});
    cyc = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("midrun_aen", a_en1, 1);
    tick();
    rst_n = 1'b0;
    #1;
    rst_chk("midrun_rst", 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrun_drop", sb.size(), 0);
    go(0, 8'd4, 8'h00, 8'h10, 8'h20, 0);
    go(0, 8'd0, 8'h33, 8'h44, 8'h55, 0);
    mem_a[8'h30] = 16'hFFFF;
    mem_b[8'h40] = 16'h0002;
    go(0, 8'd1, 8'h30, 8'h40, 8'h50, 0);
    mem_a[8'h60] = 16'h1234;
    mem_b[8'h70] = 16'h0001;
    go(0, 8'd1, 8'h60, 8'h70, 8'h80, 0);
    go(0, 8'd3, 8'hFE, 8'h80, 8'hFF, 0);
    go(1, 8'd5, 8'h90, 8'hA0, 8'hB0, 1);
    go(1, 8'd3, 8'hFE, 8'h81, 8'hFF, 0);
    go(1, 8'd0, 8'h00, 8'h00, 8'h00, 0);
    go(1, 8'd20, 8'h05, 8'hC7, 8'h3C, 0);
    go(0, 8'd12, 8'hF8, 8'h09, 8'hFA, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bram_add_seq.md
# bram_add_seq

Sequencer for the BRAM adder datapath. It walks operand BRAMs A and B element by element from programmable base addresses and adds each pair. Each sum is written to result BRAM R. It replaces the free-running binary address counters with a start/done-controlled address engine that issues one element pair per cycle. It sits between the top-level control logic and the three block-RAM ports.

## Interface
Parameters:
- ADDR_W, 8, BRAM address width; all addresses wrap modulo 2^ADDR_W
- DATA_W, 16, operand and result data width
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a run; sampled only in IDLE
- len  in  ADDR_W  number of element pairs; 0 is legal (no-op run)
- a_base, b_base, r_base  in  ADDR_W each  base addresses; captured together with len when start is accepted
- busy  out  1  high from the first issue cycle through the last write cycle
- done  out  1  one-cycle pulse at the end of a run
- ovf  out  1  sticky carry-out flag for the current or most recent run
- a_en, b_en  out  1  BRAM A/B read enables
- a_addr, b_addr  out  ADDR_W  BRAM A/B read addresses
- a_dout, b_dout  in  DATA_W  BRAM A/B read data
- r_we  out  1  BRAM R write enable
- r_addr  out  ADDR_W  BRAM R write address
- r_din  out  DATA_W  BRAM R write data; low DATA_W bits of the sum

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with start=1 and len≠0: capture len and the three base addresses, clear ovf, go to RUN.
- IDLE with start=1 and len=0: clear ovf, go to DONE. No BRAM access occurs.
- RUN: assert a_en/b_en. Present a_addr=a_base+k and b_addr=b_base+k for k=0..len-1, one k per cycle. After issuing k=len-1, go to DRAIN.
- DRAIN: hold a_en/b_en low. Stay until the last write has been issued, then go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Pipeline:
  - A valid bit plus an index travel through an RD_LAT-deep shift register alongside each issued read.
  - On the returning cycle, register sum = a_dout + b_dout at width DATA_W+1.
  - The next cycle drives r_we=1, r_addr=r_base+k and r_din=sum[DATA_W-1:0].
  - If sum[DATA_W]=1, set ovf.
- ovf holds its value until the next accepted start.
- start is ignored in RUN, DRAIN and DONE. There is no queuing of requests.
- Address arithmetic wraps: base 0xFE with len 4 accesses 0xFE, 0xFF, 0x00, 0x01.
- rst_n low at any time, including mid-run, forces the state to IDLE and clears the pipeline valid bits. Pending writes are dropped.

## Timing
- Reset values: busy=0, done=0, ovf=0, a_en=b_en=r_we=0. All addresses and r_din are 0.
- Cycle 0: start is accepted.
- Cycle 1+k: read k is issued.
- Cycle 1+k+RD_LAT: read data is sampled and the sum is registered.
- Cycle 2+k+RD_LAT: r_we is high for element k.
- Cycle 2+len+RD_LAT: done pulses. busy is low in this cycle.
- busy is high during cycles 1 through 1+len+RD_LAT.
- Throughput is 1 pair per cycle, with no bubbles inside a run.
- len=0: done pulses in cycle 1 and busy never rises.
- Earliest next start is the cycle after done, which is back in IDLE.

## Structure
- Package bram_add_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - default widths ADDR_W/DATA_W
  - the RD_LAT legal-range constants
- One sub-module, bram_add_pipe:
  - the RD_LAT valid/index delay line, the adder and the write-stage registers
  - parameterised by ADDR_W, DATA_W, RD_LAT
- The top level holds the FSM, the issue counter and base-address capture.

## Test plan
- Reset mid-run:
  - Stimulus: RD_LAT=1, len=4, bases 0/0x10/0x20, A[i]=i, B[i]=0x100 for i=0..3. Assert rst_n=0 in cycle 3, then release.
  - Required: all outputs return to their reset values immediately; no further r_we.
  - Then issue start again with the same settings. Required: writes R[0x20..0x23]=0x100..0x103 in cycles 3..6, done in cycle 7, ovf=0.
- len=0: start -> done in cycle 1; no a_en, b_en or r_we ever asserted; busy stays 0.
- Overflow:
  - Stimulus: A[0]=0xFFFF, B[0]=0x0002, len=1.
  - Required: R[r_base]=0x0001, ovf=1 after the write, ovf still 1 after done.
  - A following run with no carry clears ovf at its start.
- Wrap-around:
  - Stimulus: a_base=0xFE, r_base=0xFF, len=3.
  - Required: read addresses 0xFE, 0xFF, 0x00 and write addresses 0xFF, 0x00, 0x01.
- RD_LAT=2 with len=5:
  - Required: r_we high in cycles 4..8, done in cycle 9.
  - start pulsed during RUN is ignored: exactly 5 writes occur.
